// File: rtl/fft_tw_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : fft_tw_pkg                                                  |
// | Purpose    : Shared constants and helpers for the FFT twiddle server:    |
// |              binary64 sign position, quadrant codes, sign flip, quarter  |
// |              table length and the quarter-wave cosine table contents.    |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package fft_tw_pkg;

   localparam int SIGN_BIT = 63;

   // Quadrant of the circle, taken from the two index MSBs
   localparam logic [1:0] QUAD_0 = 2'd0;
   localparam logic [1:0] QUAD_1 = 2'd1;
   localparam logic [1:0] QUAD_2 = 2'd2;
   localparam logic [1:0] QUAD_3 = 2'd3;

   localparam real C_PI = 3.141592653589793;

   // Negation of a binary64 value is a pure sign toggle; +0.0 becomes -0.0
   function automatic logic [63:0] flip_sign(input logic [63:0] x);
      return x ^ (64'd1 << SIGN_BIT);
   endfunction

   // Quarter-wave length Q = M/4 = 2^(logn-1)
   function automatic int quarter_len(input int logn);
      return 1 << (logn - 1);
   endfunction

   // Table word C[a] = cos(2*pi*a/M), M = 4*q. The two end points are pinned
   // to exact 1.0 and +0.0 so quadrant boundaries produce exact axis values.
   function automatic logic [63:0] cos_word(input int a, input int q);
      if (a == 0)
         return 64'h3FF0_0000_0000_0000;
      else if (a == q)
         return 64'h0000_0000_0000_0000;
      else
         return $realtobits($cos((2.0 * C_PI * real'(a)) / real'(4 * q)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twiddle_server_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface  : fft_twiddle_server_if                                       |
// | Purpose    : Three-lane twiddle request/response bundle.                |
// |              master : drives req_valid_n / tw_idx_n, receives responses |
// |              slave  : receives requests, drives rsp_valid_n, s_re_n,    |
// |                       s_im_n                                            |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface fft_twiddle_server_if #(
   parameter int FLOAT_PRECISION = 64,
   parameter int logn            = 8
);
   logic                       req_valid_1, req_valid_2, req_valid_3;
   logic [logn:0]              tw_idx_1, tw_idx_2, tw_idx_3;
   logic                       rsp_valid_1, rsp_valid_2, rsp_valid_3;
   logic [FLOAT_PRECISION-1:0] s_re_1, s_re_2, s_re_3;
   logic [FLOAT_PRECISION-1:0] s_im_1, s_im_2, s_im_3;

   modport master (
      output req_valid_1, req_valid_2, req_valid_3,
      output tw_idx_1, tw_idx_2, tw_idx_3,
      input  rsp_valid_1, rsp_valid_2, rsp_valid_3,
      input  s_re_1, s_re_2, s_re_3,
      input  s_im_1, s_im_2, s_im_3
   );

   modport slave (
      input  req_valid_1, req_valid_2, req_valid_3,
      input  tw_idx_1, tw_idx_2, tw_idx_3,
      output rsp_valid_1, rsp_valid_2, rsp_valid_3,
      output s_re_1, s_re_2, s_re_3,
      output s_im_1, s_im_2, s_im_3
   );
endinterface
`default_nettype wire

// File: rtl/fft_twiddle_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fft_twiddle_lane                                           |
// | Purpose    : One twiddle lane. 2-cycle pipeline: index fold into        |
// |              quadrant/addresses, then dual quarter-table read with      |
// |              cos/sin swap and sign toggles. Output W = cos - j*sin.     |
// | Ports      : clk, rst_n (async, active-low)                             |
// |              req_valid, tw_idx[logn:0]  - request                       |
// |              inv (FFT_TW_INV_EN only)   - return conjugate twiddle      |
// |              rsp_valid, s_re, s_im       - response (held when idle)     |
// | Options    : FFT_TW_INV_EN adds the inv input                            |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fft_twiddle_lane
   import fft_tw_pkg::*;
#(
   parameter int FLOAT_PRECISION = 64,
   parameter int logn            = 8
) (
   input  wire logic                       clk,
   input  wire logic                       rst_n,
   input  wire logic                       req_valid,
   input  wire logic [logn:0]              tw_idx,
`ifdef FFT_TW_INV_EN
   input  wire logic                       inv,
`endif
   output logic                            rsp_valid,
   output logic [FLOAT_PRECISION-1:0]      s_re,
   output logic [FLOAT_PRECISION-1:0]      s_im
);

   localparam int              Q        = quarter_len(logn);
   localparam logic [logn-1:0] C_Q_ADDR = logn'(Q);

   // Quarter-wave table, Q+1 entries: a = Q is reached when the fold offset is 0
   logic [FLOAT_PRECISION-1:0] w_rom [0:Q];

   for (genvar a = 0; a <= Q; a++) begin : g_rom
      assign w_rom[a] = cos_word(a, Q);
   end

   // ---------------- stage 1: fold ----------------
   logic            r_v1;
   logic [1:0]      r_quad;
   logic [logn-1:0] r_addr_a;
   logic [logn-1:0] r_addr_b;
   logic [logn-1:0] w_r;

   assign w_r = {1'b0, tw_idx[logn-2:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1     <= 1'b0;
         r_quad   <= QUAD_0;
         r_addr_a <= '0;
         r_addr_b <= '0;
      end else begin
         r_v1 <= req_valid;
         if (req_valid) begin
            r_quad   <= tw_idx[logn:logn-1];
            r_addr_a <= w_r;
            r_addr_b <= C_Q_ADDR - w_r;
         end
      end
   end

`ifdef FFT_TW_INV_EN
   logic r_inv1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_inv1 <= 1'b0;
      else if (req_valid)
         r_inv1 <= inv;
   end
`endif

   // ---------------- stage 2: read + quadrant map ----------------
   logic [FLOAT_PRECISION-1:0] w_ca, w_cb, w_cos, w_sin, w_im;

   assign w_ca = w_rom[r_addr_a];
   assign w_cb = w_rom[r_addr_b];

   always_comb begin
      w_cos = w_ca;
      w_sin = w_cb;
      case (r_quad)
         QUAD_0: begin w_cos = w_ca;            w_sin = w_cb;            end
         QUAD_1: begin w_cos = flip_sign(w_cb); w_sin = w_ca;            end
         QUAD_2: begin w_cos = flip_sign(w_ca); w_sin = flip_sign(w_cb); end
         QUAD_3: begin w_cos = w_cb;            w_sin = flip_sign(w_ca); end
         default: begin w_cos = w_ca;           w_sin = w_cb;            end
      endcase
   end

   // Forward twiddle carries -sin; the conjugate keeps +sin
`ifdef FFT_TW_INV_EN
   assign w_im = r_inv1 ? w_sin : flip_sign(w_sin);
`else
   assign w_im = flip_sign(w_sin);
`endif

   logic                       r_rsp_valid;
   logic [FLOAT_PRECISION-1:0] r_s_re, r_s_im;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_s_re      <= '0;
         r_s_im      <= '0;
      end else begin
         r_rsp_valid <= r_v1;
         if (r_v1) begin
            r_s_re <= w_cos;
            r_s_im <= w_im;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign s_re      = r_s_re;
   assign s_im      = r_s_im;

endmodule
`default_nettype wire

// File: rtl/fft_twiddle_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : fft_twiddle_server                                         |
// | Purpose    : Responder for three independent FFT stage lanes; each lane |
// |              returns W = exp(-j*2*pi*k/M), M = 2^(logn+1), 2 cycles     |
// |              after its request, from a private quarter-wave table.      |
// | Ports      : clk, rst_n (async, active-low)                             |
// |              inv (FFT_TW_INV_EN only) - conjugate request for all lanes |
// |              bus (fft_twiddle_server_if.slave) - lane 1..3 req/rsp      |
// | Options    : FFT_TW_INV_EN adds the inv input                            |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fft_twiddle_server #(
   parameter int FLOAT_PRECISION = 64,
   parameter int logn            = 8
) (
   input wire logic             clk,
   input wire logic             rst_n,
`ifdef FFT_TW_INV_EN
   input wire logic             inv,
`endif
   fft_twiddle_server_if.slave  bus
);

   fft_twiddle_lane #(.FLOAT_PRECISION(FLOAT_PRECISION), .logn(logn)) u_lane_1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (bus.req_valid_1),
      .tw_idx    (bus.tw_idx_1),
`ifdef FFT_TW_INV_EN
      .inv       (inv),
`endif
      .rsp_valid (bus.rsp_valid_1),
      .s_re      (bus.s_re_1),
      .s_im      (bus.s_im_1)
   );

   fft_twiddle_lane #(.FLOAT_PRECISION(FLOAT_PRECISION), .logn(logn)) u_lane_2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (bus.req_valid_2),
      .tw_idx    (bus.tw_idx_2),
`ifdef FFT_TW_INV_EN
      .inv       (inv),
`endif
      .rsp_valid (bus.rsp_valid_2),
      .s_re      (bus.s_re_2),
      .s_im      (bus.s_im_2)
   );

   fft_twiddle_lane #(.FLOAT_PRECISION(FLOAT_PRECISION), .logn(logn)) u_lane_3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (bus.req_valid_3),
      .tw_idx    (bus.tw_idx_3),
`ifdef FFT_TW_INV_EN
      .inv       (inv),
`endif
      .rsp_valid (bus.rsp_valid_3),
      .s_re      (bus.s_re_3),
      .s_im      (bus.s_im_3)
   );

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_server.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_fft_twiddle_server                                      |
// | Purpose    : Directed self-checking bench for fft_twiddle_server,       |
// |              logn = 8 (M = 512, Q = 128). Covers FFT_TW_INV_EN when the |
// |              macro is defined.                                          |
// | Revision   : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fft_twiddle_server;

   localparam logic [63:0] SGN = 64'h8000_0000_0000_0000;
   localparam real         PI  = 3.141592653589793;

   logic clk = 1'b0;
   logic rst_n;
`ifdef FFT_TW_INV_EN
   logic inv;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fft_twiddle_server_if #(.FLOAT_PRECISION(64), .logn(8)) bus ();

   fft_twiddle_server #(.FLOAT_PRECISION(64), .logn(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef FFT_TW_INV_EN
      .inv   (inv),
`endif
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] ctab(input int a);
      if (a == 0)   return 64'h3FF0_0000_0000_0000;
      if (a == 128) return 64'h0;
      return $realtobits($cos((2.0 * PI * real'(a)) / 512.0));
   endfunction

   task automatic model(input int k, input logic iv,
                        output logic [63:0] re, output logic [63:0] im);
      logic [63:0] ca, cb, c, s;
      int q, r;
      q  = (k >> 7) & 3;
      r  = k & 127;
      ca = ctab(r);
      cb = ctab(128 - r);
      case (q)
         0:       begin c = ca;       s = cb;       end
         1:       begin c = cb ^ SGN; s = ca;       end
         2:       begin c = ca ^ SGN; s = cb ^ SGN; end
         default: begin c = cb;       s = ca ^ SGN; end
      endcase
      re = c;
      im = iv ? s : (s ^ SGN);
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int n, input logic v, input int k);
      case (n)
         1:       begin bus.req_valid_1 = v; bus.tw_idx_1 = 9'(k); end
         2:       begin bus.req_valid_2 = v; bus.tw_idx_2 = 9'(k); end
         default: begin bus.req_valid_3 = v; bus.tw_idx_3 = 9'(k); end
      endcase
   endtask

   task automatic idle();
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b0;
      bus.req_valid_3 = 1'b0;
   endtask

   task automatic check_lane(input int n, input logic v_exp, input int k, input logic iv);
      logic        v;
      logic [63:0] re, im, ere, eim;
      case (n)
         1:       begin v = bus.rsp_valid_1; re = bus.s_re_1; im = bus.s_im_1; end
         2:       begin v = bus.rsp_valid_2; re = bus.s_re_2; im = bus.s_im_2; end
         default: begin v = bus.rsp_valid_3; re = bus.s_re_3; im = bus.s_im_3; end
      endcase
      model(k, iv, ere, eim);
      chk($sformatf("lane%0d_valid_k%0d", n, k), {63'd0, v}, {63'd0, v_exp});
      chk($sformatf("lane%0d_re_k%0d", n, k), re, ere);
      chk($sformatf("lane%0d_im_k%0d", n, k), im, eim);
   endtask

   task automatic check_zero(input int n, input string what);
      logic        v;
      logic [63:0] re, im;
      case (n)
         1:       begin v = bus.rsp_valid_1; re = bus.s_re_1; im = bus.s_im_1; end
         2:       begin v = bus.rsp_valid_2; re = bus.s_re_2; im = bus.s_im_2; end
         default: begin v = bus.rsp_valid_3; re = bus.s_re_3; im = bus.s_im_3; end
      endcase
      chk($sformatf("%s_lane%0d_valid", what, n), {63'd0, v}, 64'd0);
      chk($sformatf("%s_lane%0d_re", what, n), re, 64'd0);
      chk($sformatf("%s_lane%0d_im", what, n), im, 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      idle();
      bus.tw_idx_1 = '0;
      bus.tw_idx_2 = '0;
      bus.tw_idx_3 = '0;
`ifdef FFT_TW_INV_EN
      inv = 1'b0;
`endif
      #1;
      for (int n = 1; n <= 3; n++) check_zero(n, "reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // lane 1, k = 0 : (1.0, -0.0)
      drive(1, 1'b1, 0);
      tick();
      idle();
      chk("lat_lane1_not_yet_valid", {63'd0, bus.rsp_valid_1}, 64'd0);
      tick();
      chk("k0_valid", {63'd0, bus.rsp_valid_1}, 64'd1);
      chk("k0_re", bus.s_re_1, 64'h3FF0_0000_0000_0000);
      chk("k0_im", bus.s_im_1, 64'h8000_0000_0000_0000);

      // lane 2 k = 128 and lane 3 k = 256 in the same cycle
      drive(2, 1'b1, 128);
      drive(3, 1'b1, 256);
      tick();
      idle();
      tick();
      chk("k128_valid", {63'd0, bus.rsp_valid_2}, 64'd1);
      chk("k128_re", bus.s_re_2, 64'h8000_0000_0000_0000);
      chk("k128_im", bus.s_im_2, 64'hBFF0_0000_0000_0000);
      chk("k256_valid", {63'd0, bus.rsp_valid_3}, 64'd1);
      chk("k256_re", bus.s_re_3, 64'hBFF0_0000_0000_0000);
      chk("k256_im", bus.s_im_3, 64'h0000_0000_0000_0000);

      // lane 1, k = 64 then k = 448 back-to-back
      drive(1, 1'b1, 64);
      tick();
      drive(1, 1'b1, 448);
      tick();
      chk("k64_valid", {63'd0, bus.rsp_valid_1}, 64'd1);
      chk("k64_re", bus.s_re_1, 64'h3FE6_A09E_667F_3BCD);
      chk("k64_im", bus.s_im_1, 64'hBFE6_A09E_667F_3BCD);
      idle();
      tick();
      chk("k448_valid", {63'd0, bus.rsp_valid_1}, 64'd1);
      chk("k448_re", bus.s_re_1, 64'h3FE6_A09E_667F_3BCD);
      chk("k448_im", bus.s_im_1, 64'h3FE6_A09E_667F_3BCD);
      tick();
      chk("k448_hold_valid", {63'd0, bus.rsp_valid_1}, 64'd0);
      chk("k448_hold_re", bus.s_re_1, 64'h3FE6_A09E_667F_3BCD);

      // full-circle stream on all lanes, one request per cycle
      for (int i = 0; i <= 512; i++) begin
         if (i < 512) begin
            drive(1, 1'b1, i);
            drive(2, 1'b1, (i * 5 + 3) % 512);
            drive(3, 1'b1, 511 - i);
         end else begin
            idle();
         end
         tick();
         if (i >= 1) begin
            check_lane(1, 1'b1, i - 1, 1'b0);
            check_lane(2, 1'b1, ((i - 1) * 5 + 3) % 512, 1'b0);
            check_lane(3, 1'b1, 512 - i, 1'b0);
         end
      end
      tick();
      check_lane(1, 1'b0, 511, 1'b0);
      check_lane(2, 1'b0, (511 * 5 + 3) % 512, 1'b0);
      check_lane(3, 1'b0, 0, 1'b0);

      // gap in the request stream on lane 1
      drive(1, 1'b1, 5);
      tick();
      drive(1, 1'b0, 0);
      tick();
      check_lane(1, 1'b1, 5, 1'b0);
      drive(1, 1'b1, 300);
      tick();
      check_lane(1, 1'b0, 5, 1'b0);
      idle();
      tick();
      check_lane(1, 1'b1, 300, 1'b0);

      // asynchronous reset with requests in flight
      drive(1, 1'b1, 64);
      drive(2, 1'b1, 300);
      tick();
      drive(1, 1'b1, 100);
      drive(2, 1'b1, 200);
      tick();
      idle();
      check_lane(1, 1'b1, 64, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero(1, "midrst");
      check_zero(2, "midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_zero(1, $sformatf("postrst%0d", c));
         check_zero(2, $sformatf("postrst%0d", c));
      end

`ifdef FFT_TW_INV_EN
      // conjugate then forward on consecutive cycles
      drive(1, 1'b1, 64);
      inv = 1'b1;
      tick();
      inv = 1'b0;
      tick();
      idle();
      chk("inv1_k64_re", bus.s_re_1, 64'h3FE6_A09E_667F_3BCD);
      chk("inv1_k64_im", bus.s_im_1, 64'h3FE6_A09E_667F_3BCD);
      tick();
      chk("inv0_k64_im", bus.s_im_1, 64'hBFE6_A09E_667F_3BCD);
      drive(2, 1'b1, 200);
      inv = 1'b1;
      tick();
      idle();
      inv = 1'b0;
      tick();
      check_lane(2, 1'b1, 200, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
